// File: rtl/iob_modcnt_updn_pkg.sv
// Shared defaults and encodings for the up/down modulo counter.
// Direction encoding and the per-cycle operation select live here.
package iob_modcnt_updn_pkg;

  localparam int unsigned IOB_MODCNT_UPDN_DATA_W  = 8;
  localparam int unsigned IOB_MODCNT_UPDN_STEP_W  = 4;
  localparam int unsigned IOB_MODCNT_UPDN_WRAP_W  = 16;
  localparam int unsigned IOB_MODCNT_UPDN_RST_VAL = 0;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_COUNT = 2'd1,
    OP_LOAD  = 2'd2
  } op_e;

endpackage

// File: rtl/iob_modcnt_updn_reg.sv
// Register with async reset, clock enable and synchronous reset.
// The synchronous reset is gated by the clock enable.
module iob_modcnt_updn_reg #(
  parameter int unsigned      W       = 1,
  parameter logic [W-1:0]     RST_VAL = {W{1'b0}}
) (
  input  logic         clk_i,
  input  logic         arst_i,
  input  logic         cke_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  // state register: async reset, then enable-gated sync reset or load
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      q_o <= RST_VAL;
    end else if (cke_i) begin
      if (rst_i) begin
        q_o <= RST_VAL;
      end else begin
        q_o <= d_i;
      end
    end
  end

endmodule

// File: rtl/iob_modcnt_updn.sv
// Up/down modulo counter over 0..mod_i with programmable step, parallel load,
// registered terminal-count pulse and a saturating wrap counter with sticky overflow.
module iob_modcnt_updn
  import iob_modcnt_updn_pkg::*;
#(
  parameter int unsigned         DATA_W  = IOB_MODCNT_UPDN_DATA_W,
  parameter int unsigned         STEP_W  = IOB_MODCNT_UPDN_STEP_W,
  parameter int unsigned         WRAP_W  = IOB_MODCNT_UPDN_WRAP_W,
  parameter logic [DATA_W-1:0]   RST_VAL = DATA_W'(IOB_MODCNT_UPDN_RST_VAL)
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              dir_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [DATA_W-1:0] mod_i,
  input  logic              ld_i,
  input  logic [DATA_W-1:0] ld_val_i,
  output logic [DATA_W-1:0] data_o,
  output logic              tc_o,
  output logic [WRAP_W-1:0] wrap_cnt_o,
  output logic              ovf_o
);

  localparam int unsigned EW = DATA_W + 1;

  logic [DATA_W-1:0] data_q, data_d, step_nxt_s, ld_clamp_s;
  logic              tc_q, tc_d, ovf_q, ovf_d, wrap_s;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic [EW-1:0]     cnt_x_s, mod_x_s, step_x_s, mod_p1_s, sum_up_s, sum_dn_s;
  op_e               op_s;

  // One guard bit so sums across the modulo boundary never overflow
  assign cnt_x_s    = {1'b0, data_q};
  assign mod_x_s    = {1'b0, mod_i};
  assign step_x_s   = EW'(step_i);
  assign mod_p1_s   = mod_x_s + EW'(1);
  assign sum_up_s   = cnt_x_s + step_x_s;
  assign sum_dn_s   = cnt_x_s + mod_p1_s;
  assign ld_clamp_s = (ld_val_i > mod_i) ? mod_i : ld_val_i;

  // operation select: load beats count beats hold
  always_comb begin
    op_s = OP_HOLD;
    if (ld_i) begin
      op_s = OP_LOAD;
    end else if (en_i) begin
      op_s = OP_COUNT;
    end else begin
      op_s = OP_HOLD;
    end
  end

  // step result and wrap detection; an out-of-range count or step snaps to the boundary
  always_comb begin
    step_nxt_s = data_q;
    wrap_s     = 1'b0;
    if (step_x_s == {EW{1'b0}}) begin
      step_nxt_s = data_q;
    end else if (dir_i == DIR_UP) begin
      if ((cnt_x_s > mod_x_s) || (step_x_s > mod_x_s)) begin
        step_nxt_s = {DATA_W{1'b0}};
        wrap_s     = 1'b1;
      end else if (sum_up_s > mod_x_s) begin
        step_nxt_s = DATA_W'(sum_up_s - mod_p1_s);
        wrap_s     = 1'b1;
      end else begin
        step_nxt_s = DATA_W'(sum_up_s);
      end
    end else begin
      if ((cnt_x_s > mod_x_s) || (step_x_s > mod_x_s)) begin
        step_nxt_s = mod_i;
        wrap_s     = 1'b1;
      end else if (cnt_x_s < step_x_s) begin
        step_nxt_s = DATA_W'(sum_dn_s - step_x_s);
        wrap_s     = 1'b1;
      end else begin
        step_nxt_s = DATA_W'(cnt_x_s - step_x_s);
      end
    end
  end

  // next-state for all registers; tc is a pulse so it defaults low
  always_comb begin
    data_d = data_q;
    tc_d   = 1'b0;
    wrap_d = wrap_q;
    ovf_d  = ovf_q;
    case (op_s)
      OP_LOAD: begin
        data_d = ld_clamp_s;
      end
      OP_COUNT: begin
        data_d = step_nxt_s;
        tc_d   = wrap_s;
        if (wrap_s) begin
          if (&wrap_q) begin
            ovf_d = 1'b1;
          end else begin
            wrap_d = wrap_q + WRAP_W'(1);
          end
        end else begin
          wrap_d = wrap_q;
        end
      end
      default: begin
        data_d = data_q;
      end
    endcase
  end

  iob_modcnt_updn_reg #(.W(DATA_W), .RST_VAL(RST_VAL)) u_cnt_reg (
    .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .rst_i(rst_i), .d_i(data_d), .q_o(data_q)
  );

  iob_modcnt_updn_reg #(.W(1), .RST_VAL(1'b0)) u_tc_reg (
    .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .rst_i(rst_i), .d_i(tc_d), .q_o(tc_q)
  );

  iob_modcnt_updn_reg #(.W(WRAP_W), .RST_VAL({WRAP_W{1'b0}})) u_wrap_reg (
    .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .rst_i(rst_i), .d_i(wrap_d), .q_o(wrap_q)
  );

  iob_modcnt_updn_reg #(.W(1), .RST_VAL(1'b0)) u_ovf_reg (
    .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .rst_i(rst_i), .d_i(ovf_d), .q_o(ovf_q)
  );

  assign data_o     = data_q;
  assign tc_o       = tc_q;
  assign wrap_cnt_o = wrap_q;
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_iob_modcnt_updn.sv
// Directed bench for iob_modcnt_updn: expected outputs are queued as each step is
// driven and popped after the clock edge; a second instance has a 2-bit wrap counter.
module tb_iob_modcnt_updn;

  localparam logic UP = 1'b0;
  localparam logic DN = 1'b1;

  logic        clk_i = 1'b0;
  logic        arst_i, cke_i, rst_i, en_i, dir_i, ld_i;
  logic [3:0]  step_i;
  logic [7:0]  mod_i, ld_val_i;
  logic [7:0]  data_o, data2_o;
  logic        tc_o, tc2_o, ovf_o, ovf2_o;
  logic [15:0] wrap_cnt_o;
  logic [1:0]  wrap2_o;

  typedef struct {
    logic [7:0]  d;
    logic        tc;
    logic [15:0] w;
    logic        ovf;
    logic        c2;
    logic [1:0]  w2;
    logic        o2;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk_i = ~clk_i;

  iob_modcnt_updn #(.DATA_W(8), .STEP_W(4), .WRAP_W(16), .RST_VAL(8'd0)) u_dut (
    .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .rst_i(rst_i), .en_i(en_i),
    .dir_i(dir_i), .step_i(step_i), .mod_i(mod_i), .ld_i(ld_i), .ld_val_i(ld_val_i),
    .data_o(data_o), .tc_o(tc_o), .wrap_cnt_o(wrap_cnt_o), .ovf_o(ovf_o)
  );

  iob_modcnt_updn #(.DATA_W(8), .STEP_W(4), .WRAP_W(2), .RST_VAL(8'd0)) u_dut2 (
    .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .rst_i(rst_i), .en_i(en_i),
    .dir_i(dir_i), .step_i(step_i), .mod_i(mod_i), .ld_i(ld_i), .ld_val_i(ld_val_i),
    .data_o(data2_o), .tc_o(tc2_o), .wrap_cnt_o(wrap2_o), .ovf_o(ovf2_o)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ld, input logic en, input logic dir,
                       input logic [3:0] step, input logic [7:0] md, input logic [7:0] ldv,
                       input logic cke);
    rst_i = rst; ld_i = ld; en_i = en; dir_i = dir;
    step_i = step; mod_i = md; ld_val_i = ldv; cke_i = cke;
  endtask

  task automatic push(input logic [7:0] d, input logic tc, input logic [15:0] w, input logic ovf,
                      input logic c2, input logic [1:0] w2, input logic o2);
    exp_t e;
    e.d = d; e.tc = tc; e.w = w; e.ovf = ovf; e.c2 = c2; e.w2 = w2; e.o2 = o2;
    sb_q.push_back(e);
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb_q.pop_front();
      chk("data_o", {8'd0, data_o}, {8'd0, e.d});
      chk("tc_o", {15'd0, tc_o}, {15'd0, e.tc});
      chk("wrap_cnt_o", wrap_cnt_o, e.w);
      chk("ovf_o", {15'd0, ovf_o}, {15'd0, e.ovf});
      if (e.c2) begin
        chk("dut2_data_o", {8'd0, data2_o}, {8'd0, e.d});
        chk("dut2_tc_o", {15'd0, tc2_o}, {15'd0, e.tc});
        chk("dut2_wrap_cnt_o", {14'd0, wrap2_o}, {14'd0, e.w2});
        chk("dut2_ovf_o", {15'd0, ovf2_o}, {15'd0, e.o2});
      end
    end
  endtask

  task automatic step(input logic [7:0] d, input logic tc, input logic [15:0] w, input logic ovf,
                      input logic c2 = 1'b0, input logic [1:0] w2 = 2'd0, input logic o2 = 1'b0);
    push(d, tc, w, ovf, c2, w2, o2);
    @(posedge clk_i);
    #1;
    compare_head();
  endtask

  initial begin
    arst_i = 1'b1;
    drive(1'b0, 1'b0, 1'b0, UP, 4'd1, 8'd9, 8'd0, 1'b1);
    repeat (2) @(posedge clk_i);
    #1;
    push(8'd0, 1'b0, 16'd0, 1'b0, 1'b1, 2'd0, 1'b0);
    compare_head();
    arst_i = 1'b0;

    // up by 1 over 0..9
    drive(1'b0, 1'b0, 1'b1, UP, 4'd1, 8'd9, 8'd0, 1'b1);
    for (int i = 1; i <= 9; i++) step(8'(i), 1'b0, 16'd0, 1'b0);
    step(8'd0, 1'b1, 16'd1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, UP, 4'd1, 8'd9, 8'd0, 1'b1);
    step(8'd0, 1'b0, 16'd1, 1'b0);

    // up by 4 over 0..9
    drive(1'b0, 1'b0, 1'b1, UP, 4'd4, 8'd9, 8'd0, 1'b1);
    step(8'd4, 1'b0, 16'd1, 1'b0);
    step(8'd8, 1'b0, 16'd1, 1'b0);
    step(8'd2, 1'b1, 16'd2, 1'b0);
    step(8'd6, 1'b0, 16'd2, 1'b0);
    step(8'd0, 1'b1, 16'd3, 1'b0);

    // load 2 then down by 3 (load wins over enable)
    drive(1'b0, 1'b1, 1'b1, DN, 4'd3, 8'd9, 8'd2, 1'b1);
    step(8'd2, 1'b0, 16'd3, 1'b0);
    drive(1'b0, 1'b0, 1'b1, DN, 4'd3, 8'd9, 8'd2, 1'b1);
    step(8'd9, 1'b1, 16'd4, 1'b0);
    step(8'd6, 1'b0, 16'd4, 1'b0);
    step(8'd3, 1'b0, 16'd4, 1'b0);
    step(8'd0, 1'b0, 16'd4, 1'b0);
    step(8'd7, 1'b1, 16'd5, 1'b0);

    // load clamp, then count from above a shrunk modulo
    drive(1'b0, 1'b1, 1'b0, UP, 4'd1, 8'd5, 8'd200, 1'b1);
    step(8'd5, 1'b0, 16'd5, 1'b0);
    drive(1'b0, 1'b0, 1'b1, UP, 4'd1, 8'd3, 8'd0, 1'b1);
    step(8'd0, 1'b1, 16'd6, 1'b0);

    // zero step holds; step larger than modulo snaps to the boundary
    drive(1'b0, 1'b0, 1'b1, UP, 4'd0, 8'd3, 8'd0, 1'b1);
    step(8'd0, 1'b0, 16'd6, 1'b0);
    drive(1'b0, 1'b0, 1'b1, DN, 4'd5, 8'd3, 8'd0, 1'b1);
    step(8'd3, 1'b1, 16'd7, 1'b0);
    drive(1'b0, 1'b0, 1'b1, UP, 4'd5, 8'd3, 8'd0, 1'b1);
    step(8'd0, 1'b1, 16'd8, 1'b0);
    drive(1'b0, 1'b0, 1'b1, DN, 4'd3, 8'd9, 8'd0, 1'b1);
    step(8'd7, 1'b1, 16'd9, 1'b0);

    // clock enable low freezes everything, even with reset/load/enable high
    drive(1'b1, 1'b1, 1'b1, UP, 4'd1, 8'd9, 8'd4, 1'b0);
    step(8'd7, 1'b1, 16'd9, 1'b0);
    step(8'd7, 1'b1, 16'd9, 1'b0);
    drive(1'b1, 1'b1, 1'b1, UP, 4'd1, 8'd9, 8'd4, 1'b1);
    step(8'd0, 1'b0, 16'd0, 1'b0, 1'b1, 2'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, UP, 4'd1, 8'd9, 8'd4, 1'b1);
    step(8'd0, 1'b0, 16'd0, 1'b0, 1'b1, 2'd0, 1'b0);

    // modulo 0: every step wraps; the 2-bit wrap counter saturates and sets ovf
    drive(1'b0, 1'b0, 1'b1, UP, 4'd1, 8'd0, 8'd0, 1'b1);
    step(8'd0, 1'b1, 16'd1, 1'b0, 1'b1, 2'd1, 1'b0);
    step(8'd0, 1'b1, 16'd2, 1'b0, 1'b1, 2'd2, 1'b0);
    step(8'd0, 1'b1, 16'd3, 1'b0, 1'b1, 2'd3, 1'b0);
    step(8'd0, 1'b1, 16'd4, 1'b0, 1'b1, 2'd3, 1'b1);
    step(8'd0, 1'b1, 16'd5, 1'b0, 1'b1, 2'd3, 1'b1);
    drive(1'b0, 1'b0, 1'b0, UP, 4'd1, 8'd0, 8'd0, 1'b1);
    step(8'd0, 1'b0, 16'd5, 1'b0, 1'b1, 2'd3, 1'b1);

    // sync reset with a wrap pending: flags clear, no tc pulse afterwards
    drive(1'b1, 1'b0, 1'b1, UP, 4'd1, 8'd0, 8'd0, 1'b1);
    step(8'd0, 1'b0, 16'd0, 1'b0, 1'b1, 2'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, UP, 4'd1, 8'd0, 8'd0, 1'b1);
    step(8'd0, 1'b0, 16'd0, 1'b0, 1'b1, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
